// File: rtl/atomic_counter_bank_pkg.sv
// -----------------------------------------------------------------------------
// atomic_counters_pkg
// Shared types and helpers for the atomic counter bank.
//   state_t  : read FSM state (ST_IDLE, ST_BURST)
//   beats()  : number of BUS_W beats needed to return one CNT_W counter
//   idx_w()  : index width for n items, never narrower than one bit
// Optional feature macro used by this codebase slice: CLR_ON_READ_EN
// -----------------------------------------------------------------------------
package atomic_counters_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    function automatic int beats(input int cnt_w, input int bus_w);
        return cnt_w / bus_w;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/atomic_counter_bank_if.sv
// -----------------------------------------------------------------------------
// atomic_counter_bank_if
// Read port of the atomic counter bank.
//   req_i    : beat request, one beat per cycle high
//   atomic_i : with req_i in IDLE, start a snapshot burst
//   sel_i    : counter select, sampled only when a burst or live read starts
//   ack_o    : beat valid, exactly one cycle after an accepted req_i
//   count_o  : beat data, zero whenever ack_o is low
//   busy_o   : high while a snapshot burst is in progress
// Handshake: there is no back-pressure. Every req_i seen on a clock edge is
// accepted and answered by ack_o high for exactly the following cycle; the
// requester never waits for a ready.
// Modports: master drives requests (software side), slave is the bank.
// -----------------------------------------------------------------------------
interface atomic_counter_bank_if
    import atomic_counters_pkg::*;
#(
    parameter int NUM_CNT = 4,
    parameter int BUS_W   = 32
) ();

    localparam int SEL_W = idx_w(NUM_CNT);

    logic             req_i;
    logic             atomic_i;
    logic [SEL_W-1:0] sel_i;
    logic             ack_o;
    logic [BUS_W-1:0] count_o;
    logic             busy_o;

    modport master (
        output req_i, atomic_i, sel_i,
        input  ack_o, count_o, busy_o
    );

    modport slave (
        input  req_i, atomic_i, sel_i,
        output ack_o, count_o, busy_o
    );

endinterface

// File: rtl/atomic_counter_bank_cell.sv
// -----------------------------------------------------------------------------
// atomic_counter_cell
// One CNT_W-bit event counter, wraps silently at 2^CNT_W-1 -> 0.
//   clk, reset_n : clock, asynchronous active-low reset
//   inc          : add one this cycle
//   clr          : clear this cycle; a same-cycle inc leaves the counter at 1
//   cnt_o        : registered count
// -----------------------------------------------------------------------------
module atomic_counter_cell #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            // Clear then count: the event in the clearing cycle is not lost.
            cnt_q <= CNT_W'(inc);
        end else begin
            cnt_q <= cnt_q + CNT_W'(inc);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/atomic_counter_bank.sv
// -----------------------------------------------------------------------------
// atomic_counter_bank
// Bank of NUM_CNT event counters read over a BUS_W-bit port in CNT_W/BUS_W
// beats. An atomic request snapshots the selected counter so the remaining
// beats come from one consistent value while counting continues.
//   clk, reset_n : clock, asynchronous active-low reset
//   trig_i       : per-counter increment strobe
//   bus          : read port (atomic_counter_bank_if.slave)
//   state_o      : read FSM state, for observation
// Macro CLR_ON_READ_EN: when defined, an atomic start also clears the
// selected counter (the snapshot keeps the pre-clear value). Live reads never
// clear. When undefined, reads are non-destructive.
// -----------------------------------------------------------------------------
module atomic_counter_bank
    import atomic_counters_pkg::*;
#(
    parameter int NUM_CNT = 4,
    parameter int CNT_W   = 64,
    parameter int BUS_W   = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_CNT-1:0]   trig_i,
    atomic_counter_bank_if.slave bus,
    output state_t               state_o
);

    localparam int BEATS  = beats(CNT_W, BUS_W);
    localparam int BIDX_W = idx_w(BEATS);

    generate
        if ((CNT_W % BUS_W) != 0 || BEATS < 2) begin : g_cfg_err
            $fatal(1, "atomic_counter_bank: CNT_W must be a multiple of BUS_W with at least 2 beats");
        end
    endgenerate

    logic [CNT_W-1:0]  cnt [NUM_CNT];
    logic [NUM_CNT-1:0] clr;
    logic [CNT_W-1:0]  sel_cnt;
    logic              sel_valid;
    logic              start_atomic;

    state_t            state;
    logic [BIDX_W-1:0] bidx;
    logic [CNT_W-1:0]  snap;
    logic              ack_q;
    logic [BUS_W-1:0]  count_q;
    logic              busy_q;

    // Select mux over registered counter values. An out-of-range select
    // matches no counter and reads as zero.
    always_comb begin
        sel_cnt   = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (int'(bus.sel_i) == i) begin
                sel_cnt   = cnt[i];
                sel_valid = 1'b1;
            end
        end
        start_atomic = (state == ST_IDLE) && bus.req_i && bus.atomic_i && sel_valid;
    end

`ifdef CLR_ON_READ_EN
    always_comb begin
        clr = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (start_atomic && int'(bus.sel_i) == i) begin
                clr[i] = 1'b1;
            end
        end
    end
`else
    assign clr = '0;
`endif

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cell
        atomic_counter_cell #(
            .CNT_W (CNT_W)
        ) u_cell (
            .clk     (clk),
            .reset_n (reset_n),
            .inc     (trig_i[i]),
            .clr     (clr[i]),
            .cnt_o   (cnt[i])
        );
    end

    // Read FSM. Outputs are registered so a beat appears exactly one cycle
    // after its request and ack/count fall to zero in every other cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            bidx    <= '0;
            snap    <= '0;
            ack_q   <= 1'b0;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            ack_q   <= 1'b0;
            count_q <= '0;
            case (state)
                ST_IDLE: begin
                    if (bus.req_i) begin
                        ack_q   <= 1'b1;
                        count_q <= sel_cnt[BUS_W-1:0];
                        if (start_atomic) begin
                            // Snapshot the registered value: a trigger in this
                            // same cycle lands in the counter, not the snapshot.
                            snap   <= sel_cnt;
                            bidx   <= BIDX_W'(1);
                            state  <= ST_BURST;
                            busy_q <= 1'b1;
                        end
                    end
                end
                ST_BURST: begin
                    // sel_i and atomic_i are ignored until the burst ends.
                    if (bus.req_i) begin
                        ack_q   <= 1'b1;
                        count_q <= snap[int'(bidx)*BUS_W +: BUS_W];
                        if (bidx == BIDX_W'(BEATS - 1)) begin
                            bidx   <= '0;
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            bidx <= bidx + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack_o   = ack_q;
    assign bus.count_o = count_q;
    assign bus.busy_o  = busy_q;
    assign state_o     = state;

endmodule

// File: tb/tb_atomic_counter_bank.sv
// -----------------------------------------------------------------------------
// tb_atomic_counter_bank
// Self-checking bench for atomic_counter_bank (NUM_CNT=4, CNT_W=64, BUS_W=32).
// Expected beats are pushed to exp_q when a request is driven and popped when
// the beat is due one cycle later. Large counter values are preloaded by
// briefly forcing a counter register; all expectations come from the bench.
// -----------------------------------------------------------------------------
module tb_atomic_counter_bank;
    import atomic_counters_pkg::*;

    localparam int NUM_CNT = 4;
    localparam int CNT_W   = 64;
    localparam int BUS_W   = 32;

    logic               clk     = 1'b0;
    logic               reset_n = 1'b0;
    logic [NUM_CNT-1:0] trig_i  = '0;
    state_t             state_o;

    int errors = 0;
    int checks = 0;

    logic [BUS_W-1:0] exp_q[$];
    logic [BUS_W-1:0] exp_v;
    logic [CNT_W-1:0] preload_val;

    atomic_counter_bank_if #(.NUM_CNT(NUM_CNT), .BUS_W(BUS_W)) bus ();

    atomic_counter_bank #(
        .NUM_CNT (NUM_CNT),
        .CNT_W   (CNT_W),
        .BUS_W   (BUS_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .trig_i  (trig_i),
        .bus     (bus),
        .state_o (state_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // Drive one cycle of inputs, pass one rising edge, return 1 time unit
    // after it with req/atomic/trig dropped (sel is left as driven).
    task automatic tick(input logic [NUM_CNT-1:0] trig, input logic req,
                        input logic atomic, input logic [1:0] sel);
        trig_i       = trig;
        bus.req_i    = req;
        bus.atomic_i = atomic;
        bus.sel_i    = sel;
        @(posedge clk);
        #1;
        trig_i       = '0;
        bus.req_i    = 1'b0;
        bus.atomic_i = 1'b0;
    endtask

    // Load a counter register between clock edges.
    task automatic preload(input int idx, input logic [CNT_W-1:0] val);
        preload_val = val;
        case (idx)
            0: force dut.g_cell[0].u_cell.cnt_q = preload_val;
            1: force dut.g_cell[1].u_cell.cnt_q = preload_val;
            2: force dut.g_cell[2].u_cell.cnt_q = preload_val;
            default: force dut.g_cell[3].u_cell.cnt_q = preload_val;
        endcase
        #1;
        case (idx)
            0: release dut.g_cell[0].u_cell.cnt_q;
            1: release dut.g_cell[1].u_cell.cnt_q;
            2: release dut.g_cell[2].u_cell.cnt_q;
            default: release dut.g_cell[3].u_cell.cnt_q;
        endcase
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.ack_o !== 1'b0 || bus.count_o !== '0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b count=%h busy=%b, need 0 0 0", bus.ack_o, bus.count_o, bus.busy_o);
        end
        checks++;
        if (state_o !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: state=%0d, need IDLE", state_o);
        end
        reset_n = 1'b1;
        for (int s = 0; s < NUM_CNT; s++) begin
            exp_q.push_back('0);
            tick('0, 1'b1, 1'b0, 2'(s));
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.ack_o !== 1'b1 || bus.count_o !== exp_v) begin
                errors++;
                $display("FAIL reset_live_read%0d: ack=%b count=%h, need ack=1 count=%h", s, bus.ack_o, bus.count_o, exp_v);
            end
        end
    endtask

    task automatic test_live_read();
        repeat (5) tick(4'b0010, 1'b0, 1'b0, 2'd0);
        exp_q.push_back(32'd5);
        tick('0, 1'b1, 1'b0, 2'd1);
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.ack_o !== 1'b1 || bus.count_o !== exp_v || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL live_read: ack=%b count=%h busy=%b, need 1 %h 0", bus.ack_o, bus.count_o, bus.busy_o, exp_v);
        end
        tick('0, 1'b0, 1'b0, 2'd1);
        checks++;
        if (bus.ack_o !== 1'b0 || bus.count_o !== '0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL live_idle: ack=%b count=%h busy=%b, need 0 0 0", bus.ack_o, bus.count_o, bus.busy_o);
        end
    endtask

    task automatic test_atomic_no_tear();
        logic [BUS_W-1:0] exp_b [4];
        logic             exp_busy [4];
        logic             do_atomic [4];
        logic [3:0]       trig [4];
        preload(2, 64'h0000_0001_FFFF_FFFF);
        // Counter 2 keeps counting through the burst: 1_FFFF_FFFF at the
        // snapshot edge, 2_0000_0001 when the second read starts.
        exp_b[0] = 32'hFFFF_FFFF;  exp_busy[0] = 1'b1; do_atomic[0] = 1'b1; trig[0] = 4'b0100;
        exp_b[1] = 32'h0000_0001;  exp_busy[1] = 1'b0; do_atomic[1] = 1'b0; trig[1] = 4'b0100;
`ifdef CLR_ON_READ_EN
        exp_b[2] = 32'h0000_0002;  exp_b[3] = 32'h0000_0000;
`else
        exp_b[2] = 32'h0000_0001;  exp_b[3] = 32'h0000_0002;
`endif
        exp_busy[2] = 1'b1; do_atomic[2] = 1'b1; trig[2] = 4'b0000;
        exp_busy[3] = 1'b0; do_atomic[3] = 1'b0; trig[3] = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            exp_q.push_back(exp_b[b]);
            tick(trig[b], 1'b1, do_atomic[b], 2'd2);
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.ack_o !== 1'b1 || bus.count_o !== exp_v || bus.busy_o !== exp_busy[b]) begin
                errors++;
                $display("FAIL no_tear_beat%0d: ack=%b count=%h busy=%b, need 1 %h %b", b, bus.ack_o, bus.count_o, bus.busy_o, exp_v, exp_busy[b]);
            end
        end
    endtask

    task automatic test_gap_sel_change();
        preload(2, 64'hDEAD_BEEF_1234_5678);
        exp_q.push_back(32'h1234_5678);
        exp_q.push_back(32'hDEAD_BEEF);
        tick('0, 1'b1, 1'b1, 2'd2);
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.ack_o !== 1'b1 || bus.count_o !== exp_v || state_o !== ST_BURST) begin
            errors++;
            $display("FAIL gap_beat0: ack=%b count=%h state=%0d, need 1 %h BURST", bus.ack_o, bus.count_o, state_o, exp_v);
        end
        for (int g = 0; g < 3; g++) begin
            tick('0, 1'b0, 1'b0, 2'd0);
            checks++;
            if (bus.ack_o !== 1'b0 || bus.count_o !== '0 || bus.busy_o !== 1'b1) begin
                errors++;
                $display("FAIL gap_idle%0d: ack=%b count=%h busy=%b, need 0 0 1", g, bus.ack_o, bus.count_o, bus.busy_o);
            end
        end
        tick('0, 1'b1, 1'b1, 2'd0);
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.ack_o !== 1'b1 || bus.count_o !== exp_v || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL gap_beat1: ack=%b count=%h busy=%b, need 1 %h 0", bus.ack_o, bus.count_o, bus.busy_o, exp_v);
        end
        tick('0, 1'b0, 1'b0, 2'd0);
        checks++;
        if (bus.ack_o !== 1'b0 || bus.count_o !== '0) begin
            errors++;
            $display("FAIL gap_after: ack=%b count=%h, need 0 0", bus.ack_o, bus.count_o);
        end
    endtask

    task automatic test_wrap();
        preload(3, '1);
        tick(4'b1000, 1'b0, 1'b0, 2'd0);
        for (int b = 0; b < 2; b++) begin
            exp_q.push_back('0);
            tick('0, 1'b1, (b == 0), 2'd3);
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.ack_o !== 1'b1 || bus.count_o !== exp_v) begin
                errors++;
                $display("FAIL wrap_beat%0d: ack=%b count=%h, need 1 %h", b, bus.ack_o, bus.count_o, exp_v);
            end
        end
    endtask

    task automatic test_random_count();
        int n;
        int cycles;
        logic t;
        n = 0;
        cycles = $urandom_range(20, 60);
        for (int c = 0; c < cycles; c++) begin
            t = 1'($urandom_range(0, 1));
            tick({t, 3'b000}, 1'b0, 1'b0, 2'd0);
            n += int'(t);
        end
        exp_q.push_back(BUS_W'(n));
        exp_q.push_back('0);
        for (int b = 0; b < 2; b++) begin
            tick('0, 1'b1, (b == 0), 2'd3);
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.ack_o !== 1'b1 || bus.count_o !== exp_v) begin
                errors++;
                $display("FAIL random_beat%0d: ack=%b count=%h, need 1 %h", b, bus.ack_o, bus.count_o, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [BUS_W-1:0] exp_b [5];
        logic             at [5];
        logic [1:0]       sl [5];
        logic             bz [5];
        preload(0, 64'h0000_00AA_0000_0055);
        // burst of cnt[0], live read of cnt[1], burst of cnt[1] -- no idle gaps
        exp_b[0] = 32'h55; at[0] = 1'b1; sl[0] = 2'd0; bz[0] = 1'b1;
        exp_b[1] = 32'hAA; at[1] = 1'b0; sl[1] = 2'd0; bz[1] = 1'b0;
        exp_b[2] = 32'h05; at[2] = 1'b0; sl[2] = 2'd1; bz[2] = 1'b0;
        exp_b[3] = 32'h05; at[3] = 1'b1; sl[3] = 2'd1; bz[3] = 1'b1;
        exp_b[4] = 32'h00; at[4] = 1'b0; sl[4] = 2'd1; bz[4] = 1'b0;
        for (int k = 0; k < 5; k++) exp_q.push_back(exp_b[k]);
        for (int k = 0; k < 5; k++) begin
            tick('0, 1'b1, at[k], sl[k]);
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.ack_o !== 1'b1 || bus.count_o !== exp_v || bus.busy_o !== bz[k]) begin
                errors++;
                $display("FAIL b2b_beat%0d: ack=%b count=%h busy=%b, need 1 %h %b", k, bus.ack_o, bus.count_o, bus.busy_o, exp_v, bz[k]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        preload(1, 64'h0000_0009_0000_0008);
        exp_q.push_back(32'h8);
        tick('0, 1'b1, 1'b1, 2'd1);
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.ack_o !== 1'b1 || bus.count_o !== exp_v || bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_beat0: ack=%b count=%h busy=%b, need 1 %h 1", bus.ack_o, bus.count_o, bus.busy_o, exp_v);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.ack_o !== 1'b0 || bus.count_o !== '0 || bus.busy_o !== 1'b0 || state_o !== ST_IDLE) begin
            errors++;
            $display("FAIL mid_reset: ack=%b count=%h busy=%b state=%0d, need 0 0 0 IDLE", bus.ack_o, bus.count_o, bus.busy_o, state_o);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int s = 1; s <= 2; s++) begin
            exp_q.push_back('0);
            exp_q.push_back('0);
            for (int b = 0; b < 2; b++) begin
                tick('0, 1'b1, (b == 0), 2'(s));
                exp_v = exp_q.pop_front();
                checks++;
                if (bus.ack_o !== 1'b1 || bus.count_o !== exp_v || bus.busy_o !== (b == 0)) begin
                    errors++;
                    $display("FAIL post_reset_sel%0d_beat%0d: ack=%b count=%h busy=%b, need 1 %h %b", s, b, bus.ack_o, bus.count_o, bus.busy_o, exp_v, (b == 0));
                end
            end
        end
    endtask

`ifdef CLR_ON_READ_EN
    task automatic test_clr_on_read();
        repeat (7) tick(4'b0001, 1'b0, 1'b0, 2'd0);
        exp_q.push_back(32'd7);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        for (int b = 0; b < 3; b++) begin
            tick((b == 0) ? 4'b0001 : 4'b0000, 1'b1, (b == 0), 2'd0);
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.ack_o !== 1'b1 || bus.count_o !== exp_v) begin
                errors++;
                $display("FAIL clr_beat%0d: ack=%b count=%h, need 1 %h", b, bus.ack_o, bus.count_o, exp_v);
            end
        end
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        bus.req_i    = 1'b0;
        bus.atomic_i = 1'b0;
        bus.sel_i    = '0;
        test_reset();
        test_live_read();
        test_atomic_no_tear();
        test_gap_sel_change();
        test_wrap();
        test_random_count();
        test_back_to_back();
        test_reset_mid_burst();
`ifdef CLR_ON_READ_EN
        test_clr_on_read();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
